// File: rtl/countdown_ctrl_pkg.sv
// Shared types and sizing helpers for the countdown digit source.
package countdown_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} cd_state_t;

  localparam int PRESCALE_DEF = 50_000_000;
  localparam int PRESC_W_DEF  = $clog2(PRESCALE_DEF);

  // Prescaler width for a given period; never narrower than one bit.
  function automatic int presc_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/countdown_ctrl_if.sv
// Control/display bundle between the button/load source and the countdown block.
interface countdown_ctrl_if #(
  parameter int NUM_DIGITS = 2
);
  logic                    start_btn;
  logic                    stop_btn;
  logic                    load_i;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic                    mode_up;
  logic [4*NUM_DIGITS-1:0] digits_o;
  logic                    running_o;
  logic                    done_o;

  modport master (
    output start_btn, stop_btn, load_i, load_val, mode_up,
    input  digits_o, running_o, done_o
  );

  modport slave (
    input  start_btn, stop_btn, load_i, load_val, mode_up,
    output digits_o, running_o, done_o
  );
endinterface

// File: rtl/countdown_ctrl_btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button plus a rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);
  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], btn_i};
    prev_d = sync_q[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // A held button only produces the pulse on its first synchronised cycle.
  assign pulse_o = sync_q[1] & ~prev_q;
endmodule

// File: rtl/countdown_ctrl.sv
// N-digit hex up/down counter stepping once per prescaled tick, with
// start/stop button control and a done pulse at the terminal value.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int PRESCALE   = PRESCALE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  countdown_ctrl_if.slave  bus
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = presc_width(PRESCALE);

  cd_state_t     state_q, state_d;
  logic [W-1:0]  count_q, count_d;
  logic          dir_q, dir_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;

  logic [1:0]    btn_raw, btn_pulse;
  logic          start_p, stop_p;
  logic          tick;
  logic [W-1:0]  step_val;
  logic          load_acc, latch_dir, step_acc;

  function automatic logic is_term(input logic [W-1:0] v, input logic up);
    return up ? (&v) : ~(|v);
  endfunction

  assign btn_raw = {bus.stop_btn, bus.start_btn};

  btn_sync_edge u_btn [1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_raw),
    .pulse_o (btn_pulse)
  );

  assign start_p  = btn_pulse[0];
  assign stop_p   = btn_pulse[1];
  assign tick     = (presc_q == PW'(PRESCALE - 1));
  assign step_val = dir_q ? (count_q + W'(1)) : (count_q - W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      dir_q   <= 1'b0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  // Next state plus the datapath strobes it implies. Load beats buttons,
  // and stop beats start when both pulse together.
  always_comb begin
    state_d   = state_q;
    load_acc  = 1'b0;
    latch_dir = 1'b0;
    step_acc  = 1'b0;
    done_d    = 1'b0;
    if (bus.load_i && state_q != RUN) begin
      load_acc = 1'b1;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_p && !stop_p) begin
            latch_dir = 1'b1;
            if (is_term(count_q, bus.mode_up)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (stop_p) begin
            state_d = PAUSED;
          end else if (tick) begin
            step_acc = 1'b1;
            if (is_term(step_val, dir_q)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        PAUSED: begin
          if (stop_p)       state_d = IDLE;
          else if (start_p) state_d = RUN;
        end
        DONE: state_d = DONE;
      endcase
    end
  end

  // Prescaler only advances while staying in RUN, so every (re)entry to RUN
  // starts a full period.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    presc_d = '0;
    if (load_acc)  count_d = bus.load_val;
    if (latch_dir) dir_d   = bus.mode_up;
    if (step_acc)  count_d = step_val;
    if (state_q == RUN && state_d == RUN && !tick) presc_d = presc_q + PW'(1);
  end

  always_comb begin
    bus.digits_o  = count_q;
    bus.running_o = (state_q == RUN);
    bus.done_o    = done_q;
  end
endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed plus randomised bench for countdown_ctrl against a cycle-level
// behavioural model of the counter, buttons and state rules.
module tb_countdown_ctrl;
  localparam int ND = 2;
  localparam int P  = 4;
  localparam int W  = 4 * ND;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  countdown_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  countdown_ctrl #(.NUM_DIGITS(ND), .PRESCALE(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Model: 0 idle, 1 run, 2 paused, 3 done.
  int m_state   = 0;
  int m_count   = 0;
  int m_elapsed = 0;
  bit m_dir     = 1'b0;
  bit m_done    = 1'b0;
  bit sa1 = 0, sa2 = 0, sa3 = 0;
  bit so1 = 0, so2 = 0, so3 = 0;

  always @(posedge clk or negedge rst_n) begin : model
    bit sp, tp;
    int term;
    if (!rst_n) begin
      m_state = 0; m_count = 0; m_elapsed = 0; m_dir = 0; m_done = 0;
      sa1 = 0; sa2 = 0; sa3 = 0; so1 = 0; so2 = 0; so3 = 0;
    end else begin
      // Raw level sampled two edges ago, low three edges ago -> pulse acts now.
      sp = sa2 & ~sa3;
      tp = so2 & ~so3;
      m_done = 0;
      if (bus.load_i && m_state != 1) begin
        m_count = int'(bus.load_val);
        m_state = 0;
      end else if (m_state == 0) begin
        if (sp && !tp) begin
          m_dir = bus.mode_up;
          term  = m_dir ? 255 : 0;
          if (m_count == term) begin m_state = 3; m_done = 1; end
          else begin m_state = 1; m_elapsed = 0; end
        end
      end else if (m_state == 1) begin
        if (tp) m_state = 2;
        else begin
          m_elapsed++;
          if (m_elapsed == P) begin
            m_elapsed = 0;
            m_count = (m_count + (m_dir ? 1 : 255)) % 256;
            term = m_dir ? 255 : 0;
            if (m_count == term) begin m_state = 3; m_done = 1; end
          end
        end
      end else if (m_state == 2) begin
        if (tp) m_state = 0;
        else if (sp) begin m_state = 1; m_elapsed = 0; end
      end
      sa3 = sa2; sa2 = sa1; sa1 = bus.start_btn;
      so3 = so2; so2 = so1; so1 = bus.stop_btn;
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      checks++;
      if (bus.digits_o !== W'(m_count) || bus.running_o !== (m_state == 1) ||
          bus.done_o !== m_done) begin
        failures++;
        $display("FAIL model_cmp t=%0t digits=%h exp=%h running=%b exp=%b done=%b exp=%b",
                 $time, bus.digits_o, W'(m_count), bus.running_o, (m_state == 1),
                 bus.done_o, m_done);
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    bus.load_i = 1'b1; bus.load_val = v;
    @(negedge clk);
    bus.load_i = 1'b0;
  endtask

  task automatic press(input bit s, input bit t);
    bus.start_btn = s; bus.stop_btn = t;
    @(negedge clk);
    bus.start_btn = 1'b0; bus.stop_btn = 1'b0;
  endtask

  initial begin
    bus.start_btn = 0; bus.stop_btn = 0; bus.load_i = 0;
    bus.load_val = '0; bus.mode_up = 0;
    wait_n(3);
    chk("reset_digits", bus.digits_o, 8'h00);
    chk("reset_running", W'(bus.running_o), 8'h00);
    chk("reset_done", W'(bus.done_o), 8'h00);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // 1: count down 03 -> 00
    bus.mode_up = 0;
    do_load(8'h03);
    press(1, 0);
    wait_n(1); chk("t1_not_yet_run", W'(bus.running_o), 8'h00);
    wait_n(1); chk("t1_run_3_edges", W'(bus.running_o), 8'h01);
    wait_n(4); chk("t1_step02", bus.digits_o, 8'h02);
    wait_n(4); chk("t1_step01", bus.digits_o, 8'h01);
    wait_n(4); chk("t1_step00", bus.digits_o, 8'h00);
    chk("t1_done_pulse", W'(bus.done_o), 8'h01);
    chk("t1_stopped", W'(bus.running_o), 8'h00);
    wait_n(1); chk("t1_done_one_cycle", W'(bus.done_o), 8'h00);

    // 2: count up FD -> FF, then starts ignored in DONE
    bus.mode_up = 1;
    do_load(8'hFD);
    press(1, 0);
    wait_n(2); chk("t2_run", W'(bus.running_o), 8'h01);
    wait_n(4); chk("t2_stepFE", bus.digits_o, 8'hFE);
    wait_n(4); chk("t2_stepFF", bus.digits_o, 8'hFF);
    chk("t2_done_pulse", W'(bus.done_o), 8'h01);
    press(1, 0);
    wait_n(8);
    chk("t2_done_holds", bus.digits_o, 8'hFF);
    chk("t2_start_ignored", W'(bus.running_o), 8'h00);

    // 3: pause holds, resume restarts a full period
    bus.mode_up = 0;
    do_load(8'h10);
    press(1, 0);
    wait_n(2);
    wait_n(4); chk("t3_step0F", bus.digits_o, 8'h0F);
    press(0, 1);
    wait_n(2); chk("t3_paused", W'(bus.running_o), 8'h00);
    wait_n(20); chk("t3_hold", bus.digits_o, 8'h0F);
    press(1, 0);
    wait_n(2); chk("t3_resume", W'(bus.running_o), 8'h01);
    wait_n(3); chk("t3_no_partial", bus.digits_o, 8'h0F);
    wait_n(1); chk("t3_step0E", bus.digits_o, 8'h0E);

    // 4: both buttons -> PAUSED; held start gives a single pulse
    press(1, 1);
    wait_n(2); chk("t4_stop_wins", W'(bus.running_o), 8'h00);
    bus.start_btn = 1;
    wait_n(20);
    bus.stop_btn = 1;
    wait_n(1);
    bus.stop_btn = 0;
    wait_n(29);
    bus.start_btn = 0;
    wait_n(5);
    chk("t4_single_pulse", W'(bus.running_o), 8'h00);
    chk("t4_count", bus.digits_o, 8'h0A);

    // 5: load ignored in RUN; stop, stop -> IDLE; load works
    press(1, 0);
    wait_n(2);
    do_load(8'h55);
    chk("t5_load_ignored", bus.digits_o, 8'h0A);
    press(0, 1);
    wait_n(3);
    press(0, 1);
    wait_n(3);
    chk("t5_idle", W'(bus.running_o), 8'h00);
    do_load(8'h55);
    chk("t5_load55", bus.digits_o, 8'h55);

    // 6: start at terminal -> DONE directly; async reset mid-RUN
    bus.mode_up = 0;
    do_load(8'h00);
    press(1, 0);
    wait_n(2);
    chk("t6_direct_done", W'(bus.done_o), 8'h01);
    chk("t6_not_run", W'(bus.running_o), 8'h00);
    wait_n(1); chk("t6_done_once", W'(bus.done_o), 8'h00);
    do_load(8'h20);
    press(1, 0);
    wait_n(6);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_digits", bus.digits_o, 8'h00);
    chk("t6_async_running", W'(bus.running_o), 8'h00);
    chk("t6_async_done", W'(bus.done_o), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Random phase: toggling raw buttons gives random hold lengths.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0)  bus.start_btn = ~bus.start_btn;
      if ($urandom_range(0, 19) == 0) bus.stop_btn  = ~bus.stop_btn;
      bus.load_i  = ($urandom_range(0, 29) == 0);
      bus.mode_up = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: bus.load_val = 8'h00;
        1: bus.load_val = 8'h01;
        2: bus.load_val = 8'hFF;
        3: bus.load_val = 8'hFE;
        4: bus.load_val = 8'h03;
        default: bus.load_val = 8'($urandom);
      endcase
      @(negedge clk);
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
